// File: rtl/decode_stage_if.sv
// Handshake and bus bundle between fetch, the decode stage, the register file and writeback.
// The slave modport is the decode stage's view; master is the surrounding pipeline's view.
interface decode_stage_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            if_valid;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
   logic            if_ready;
   logic [AW-1:0]   reg_a;
   logic [AW-1:0]   reg_b;
   logic            id_valid;
   logic            id_ready;
   logic [XLEN-1:0] id_pc;
   logic [AW-1:0]   id_rd;
   logic            id_rd_we;
   logic [XLEN-1:0] id_imm;
   logic [2:0]      id_fmt;
   logic [6:0]      id_opcode;
   logic [2:0]      id_funct3;
   logic [6:0]      id_funct7;
   logic            flush;
   logic            wb_valid;
   logic [AW-1:0]   wb_rd;

   modport slave (
      input  if_valid, if_instr, if_pc, id_ready, flush, wb_valid, wb_rd,
      output if_ready, reg_a, reg_b, id_valid, id_pc, id_rd, id_rd_we, id_imm,
             id_fmt, id_opcode, id_funct3, id_funct7
   );

   modport master (
      output if_valid, if_instr, if_pc, id_ready, flush, wb_valid, wb_rd,
      input  if_ready, reg_a, reg_b, id_valid, id_pc, id_rd, id_rd_we, id_imm,
             id_fmt, id_opcode, id_funct3, id_funct7
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: format/immediate decode, output pipeline register, register-file
// read addressing and a per-register busy scoreboard interlocking RAW/WAW hazards.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter bit SB_EN = 1'b1
) (
   input logic           clk,
   input logic           reset,
   decode_stage_if.slave bus
);
   localparam int AW = $clog2(NREG);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;

   logic [XLEN-1:0] w_instr;
   logic [6:0]      w_opcode;
   logic [AW-1:0]   w_rs1;
   logic [AW-1:0]   w_rs2;
   logic [AW-1:0]   w_rd;
   logic [2:0]      w_fmt;
   logic            w_uses_rs1;
   logic            w_uses_rs2;
   logic            w_has_rd;
   logic            w_rd_we;
   logic [XLEN-1:0] w_imm;
   logic [NREG-1:0] w_busy;
   logic [NREG-1:0] w_busy_nxt;
   logic            w_hazard;
   logic            w_if_ready;
   logic            w_advance;

   logic [NREG-1:0] r_busy;
   logic            r_id_valid;
   logic [XLEN-1:0] r_id_pc;
   logic [AW-1:0]   r_id_rd;
   logic            r_id_rd_we;
   logic [XLEN-1:0] r_id_imm;
   logic [2:0]      r_id_fmt;
   logic [6:0]      r_id_opcode;
   logic [2:0]      r_id_funct3;
   logic [6:0]      r_id_funct7;
   logic [AW-1:0]   r_rs1;
   logic [AW-1:0]   r_rs2;

   assign w_instr  = bus.if_instr;
   assign w_opcode = w_instr[6:0];
   assign w_rs1    = w_instr[19:15];
   assign w_rs2    = w_instr[24:20];
   assign w_rd     = w_instr[11:7];

   always_comb begin
      // NOTE: every output of this block gets a default first, so no opcode path infers a latch.
      w_fmt      = FMT_ILL;
      w_uses_rs1 = 1'b0;
      w_uses_rs2 = 1'b0;
      w_has_rd   = 1'b0;
      w_imm      = '0;
      case (w_opcode)
         7'b0110011: begin
            w_fmt      = FMT_R;
            w_uses_rs1 = 1'b1;
            w_uses_rs2 = 1'b1;
            w_has_rd   = 1'b1;
         end
         7'b0010011, 7'b0000011, 7'b1100111: begin
            w_fmt      = FMT_I;
            w_uses_rs1 = 1'b1;
            w_has_rd   = 1'b1;
            w_imm      = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};
         end
         7'b0100011: begin
            w_fmt      = FMT_S;
            w_uses_rs1 = 1'b1;
            w_uses_rs2 = 1'b1;
            w_imm      = {{(XLEN-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
         end
         7'b1100011: begin
            w_fmt      = FMT_B;
            w_uses_rs1 = 1'b1;
            w_uses_rs2 = 1'b1;
            w_imm      = {{(XLEN-12){w_instr[31]}}, w_instr[7], w_instr[30:25],
                          w_instr[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            w_fmt    = FMT_U;
            w_has_rd = 1'b1;
            w_imm    = {w_instr[31:12], 12'b0};
         end
         7'b1101111: begin
            w_fmt    = FMT_J;
            w_has_rd = 1'b1;
            w_imm    = {{(XLEN-20){w_instr[31]}}, w_instr[19:12], w_instr[20],
                        w_instr[30:21], 1'b0};
         end
         default: ;
      endcase
   end

   assign w_rd_we = w_has_rd & (w_rd != '0);

   // x0 is never busy; hazards see only registered busy bits, so a same-cycle wb does not bypass.
   assign w_busy   = {r_busy[NREG-1:1], 1'b0};
   assign w_hazard = SB_EN & bus.if_valid & ((w_uses_rs1 & w_busy[w_rs1]) |
                                             (w_uses_rs2 & w_busy[w_rs2]) |
                                             (w_rd_we    & w_busy[w_rd]));

   assign w_if_ready = (!r_id_valid | bus.id_ready) & !w_hazard & !bus.flush;
   assign w_advance  = bus.if_valid & w_if_ready;

   // Clears apply first so a set on the same index in the same cycle wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (bus.wb_valid)
         w_busy_nxt[bus.wb_rd] = 1'b0;
      if (bus.flush && r_id_valid && r_id_rd_we)
         w_busy_nxt[r_id_rd] = 1'b0;
      if (w_advance && w_rd_we)
         w_busy_nxt[w_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the busy array is a flop scoreboard, not a RAM; it must clear on reset or a stale bit stalls issue forever.
         r_busy      <= '0;
         r_id_valid  <= 1'b0;
         r_id_pc     <= '0;
         r_id_rd     <= '0;
         r_id_rd_we  <= 1'b0;
         r_id_imm    <= '0;
         r_id_fmt    <= '0;
         r_id_opcode <= '0;
         r_id_funct3 <= '0;
         r_id_funct7 <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
      end else begin
         // NOTE: non-blocking assignments make every register here sample pre-edge values.
         r_busy <= w_busy_nxt;
         if (bus.flush) begin
            r_id_valid <= 1'b0;
         end else if (w_advance) begin
            r_id_valid  <= 1'b1;
            r_id_pc     <= bus.if_pc;
            r_id_rd     <= w_rd;
            r_id_rd_we  <= w_rd_we;
            r_id_imm    <= w_imm;
            r_id_fmt    <= w_fmt;
            r_id_opcode <= w_opcode;
            r_id_funct3 <= w_instr[14:12];
            r_id_funct7 <= w_instr[31:25];
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
         end else if (bus.id_ready) begin
            r_id_valid <= 1'b0;
         end
      end
   end

   assign bus.if_ready  = w_if_ready;
   assign bus.reg_a     = w_advance ? w_rs1 : r_rs1;
   assign bus.reg_b     = w_advance ? w_rs2 : r_rs2;
   assign bus.id_valid  = r_id_valid;
   assign bus.id_pc     = r_id_pc;
   assign bus.id_rd     = r_id_rd;
   assign bus.id_rd_we  = r_id_rd_we;
   assign bus.id_imm    = r_id_imm;
   assign bus.id_fmt    = r_id_fmt;
   assign bus.id_opcode = r_id_opcode;
   assign bus.id_funct3 = r_id_funct3;
   assign bus.id_funct7 = r_id_funct7;
endmodule
